// File: rtl/nand4_operand_shreg_pkg.sv
// Shared encodings for the NAND4 operand shift-register stage.
// State codes, fill limit and the all-ones tap pattern.
package nand4_operand_shreg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        STALL = 2'd3
    } state_t;

    localparam logic [2:0] FILL_MAX = 3'd4;
    localparam logic [3:0] ALL_ONES = 4'b1111;

endpackage

// File: rtl/nand4_operand_shreg_sat_counter_v.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter_v #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/nand4_operand_shreg.sv
// Serial-in operand stage feeding a 4-input NAND.
// Flags and counts every load that leaves all four taps at 1.
module nand4_operand_shreg
    import nand4_operand_shreg_pkg::*;
#(
    parameter bit STALL_ON_HIT = 1'b0,
    parameter int W_CNT        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_ready,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic             o_d,
    output logic             o_full,
    output logic             o_hit,
    output logic [W_CNT-1:0] o_hit_cnt
);

    state_t     state;
    state_t     state_next;
    logic [3:0] taps;
    logic [3:0] shifted;
    logic [2:0] fill;
    logic [2:0] fill_inc;
    logic       accept;
    logic       hit_next;

    assign o_ready  = (state != STALL);
    assign o_full   = (state == FULL) || (state == STALL);
    assign accept   = i_valid & o_ready & ~i_clear;
    // taps[3] is the oldest bit (operand a)
    assign shifted  = {taps[2:0], i_bit};
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 3'd1;
    assign hit_next = accept && (fill_inc == FILL_MAX)
                      && (shifted == ALL_ONES);

    assign {o_a, o_b, o_c, o_d} = taps;

    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = EMPTY;
        end else if (state == STALL) begin
            state_next = FULL;
        end else if (accept) begin
            if (hit_next && STALL_ON_HIT) begin
                state_next = STALL;
            end else if (fill_inc == FILL_MAX) begin
                state_next = FULL;
            end else begin
                state_next = FILL;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= EMPTY;
            taps  <= '0;
            fill  <= '0;
            o_hit <= 1'b0;
        end else if (i_clear) begin
            state <= EMPTY;
            taps  <= '0;
            fill  <= '0;
            o_hit <= 1'b0;
        end else begin
            state <= state_next;
            o_hit <= hit_next;
            if (accept) begin
                taps <= shifted;
                fill <= fill_inc;
            end
        end
    end

    sat_counter_v #(
        .W(W_CNT)
    ) u_hit_cnt (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .clear(i_clear),
        .inc  (hit_next),
        .count(o_hit_cnt)
    );

endmodule

// File: tb/tb_nand4_operand_shreg.sv
// Bench for nand4_operand_shreg: three parameter variants on shared inputs,
// each tracked by a bit-history reference model.
module tb_nand4_operand_shreg;

    typedef struct {
        int taps;
        int fill;
        bit stall;
        bit hit;
        int cnt;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       bit_in;
    logic       clear;
    logic [2:0] rdy, oa, ob, oc, od, ful, hit;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int   checks = 0;
    int   errors = 0;
    mdl_t m [3];
    int   soh  [3] = '{0, 1, 0};
    int   cmax [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    nand4_operand_shreg #(.STALL_ON_HIT(1'b0), .W_CNT(8)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_bit(bit_in), .i_clear(clear), .o_ready(rdy[0]),
        .o_a(oa[0]), .o_b(ob[0]), .o_c(oc[0]), .o_d(od[0]),
        .o_full(ful[0]), .o_hit(hit[0]), .o_hit_cnt(cnt0));

    nand4_operand_shreg #(.STALL_ON_HIT(1'b1), .W_CNT(8)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_bit(bit_in), .i_clear(clear), .o_ready(rdy[1]),
        .o_a(oa[1]), .o_b(ob[1]), .o_c(oc[1]), .o_d(od[1]),
        .o_full(ful[1]), .o_hit(hit[1]), .o_hit_cnt(cnt1));

    nand4_operand_shreg #(.STALL_ON_HIT(1'b0), .W_CNT(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_bit(bit_in), .i_clear(clear), .o_ready(rdy[2]),
        .o_a(oa[2]), .o_b(ob[2]), .o_c(oc[2]), .o_d(od[2]),
        .o_full(ful[2]), .o_hit(hit[2]), .o_hit_cnt(cnt2));

    function automatic mdl_t mzero();
        mdl_t z;
        z.taps = 0; z.fill = 0; z.stall = 0; z.hit = 0; z.cnt = 0;
        return z;
    endfunction

    // One clock of the stage described as history of accepted bits
    function automatic mdl_t mstep(mdl_t s, int so, int mx,
                                   bit v, bit b, bit c);
        mdl_t n = s;
        n.hit = 0;
        if (c) return mzero();
        if (s.stall) begin
            n.stall = 0;
            return n;
        end
        if (v) begin
            n.taps = (s.taps * 2 + int'(b)) % 16;
            n.fill = (s.fill >= 4) ? 4 : s.fill + 1;
            n.hit  = (n.fill == 4) && (n.taps == 15);
            if (n.hit && n.cnt < mx) n.cnt = n.cnt + 1;
            n.stall = n.hit && (so != 0);
        end
        return n;
    endfunction

    function automatic int dcnt(int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    function automatic int dtaps(int i);
        return int'({oa[i], ob[i], oc[i], od[i]});
    endfunction

    task automatic tick(input bit v, input bit b, input bit c);
        valid  = v;
        bit_in = b;
        clear  = c;
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            m[i] = mstep(m[i], soh[i], cmax[i], v, b, c);
        #1;
    endtask

    task automatic test_reset();
        valid = 0; bit_in = 0; clear = 0;
        rst_n = 0;
        #12;
        for (int i = 0; i < 3; i++) begin
            m[i] = mzero();
            checks++;
            if ({rdy[i], ful[i], hit[i]} !== 3'b100 || dtaps(i) != 0
                || dcnt(i) != 0) begin
                errors++;
                $display("FAIL reset u%0d: rdy=%b full=%b hit=%b taps=%0h cnt=%0d, want 1 0 0 0 0",
                         i, rdy[i], ful[i], hit[i], dtaps(i), dcnt(i));
            end
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_pattern();
        tick(0, 0, 1);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        checks++;
        if (dtaps(0) != 'hb || ful[0] !== 1'b1 || hit[0] !== 1'b0
            || cnt0 !== 8'd0) begin
            errors++;
            $display("FAIL fill_1011: taps=%0h full=%b hit=%b cnt=%0d, want b 1 0 0",
                     dtaps(0), ful[0], hit[0], cnt0);
        end
    endtask

    task automatic test_overlap();
        bit seq [6] = '{1, 1, 1, 1, 1, 0};
        bit exp_hit [6] = '{0, 0, 0, 1, 1, 0};
        tick(0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            tick(1, seq[k], 0);
            checks++;
            if (hit[0] !== exp_hit[k]) begin
                errors++;
                $display("FAIL overlap_hit bit%0d: got %b want %b",
                         k + 1, hit[0], exp_hit[k]);
            end
        end
        checks++;
        if (dtaps(0) != 'he || cnt0 !== 8'd2) begin
            errors++;
            $display("FAIL overlap_end: taps=%0h cnt=%0d, want e 2",
                     dtaps(0), cnt0);
        end
    endtask

    task automatic test_stall();
        tick(0, 0, 1);
        for (int k = 0; k < 4; k++) tick(1, 1, 0);
        checks++;
        if (hit[1] !== 1'b1 || rdy[1] !== 1'b0 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL stall_enter: hit=%b rdy=%b cnt=%0d, want 1 0 1",
                     hit[1], rdy[1], cnt1);
        end
        tick(1, 1, 0);
        checks++;
        if (hit[1] !== 1'b0 || rdy[1] !== 1'b1 || cnt1 !== 8'd1
            || ful[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: hit=%b rdy=%b cnt=%0d full=%b, want 0 1 1 1",
                     hit[1], rdy[1], cnt1, ful[1]);
        end
        tick(1, 1, 0);
        checks++;
        if (hit[1] !== 1'b1 || rdy[1] !== 1'b0 || cnt1 !== 8'd2) begin
            errors++;
            $display("FAIL stall_late_bit: hit=%b rdy=%b cnt=%0d, want 1 0 2",
                     hit[1], rdy[1], cnt1);
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        tick(0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            tick(1, 1, 0);
            if (hit[2] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 5 || cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL saturate: pulses=%0d cnt=%0d, want 5 3",
                     pulses, cnt2);
        end
    endtask

    task automatic test_clear();
        tick(1, 1, 1);
        checks++;
        if (dtaps(0) != 0 || ful[0] !== 1'b0 || cnt0 !== 8'd0
            || rdy[0] !== 1'b1 || hit[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_full: taps=%0h full=%b cnt=%0d rdy=%b hit=%b, want 0 0 0 1 0",
                     dtaps(0), ful[0], cnt0, rdy[0], hit[0]);
        end
        for (int k = 0; k < 4; k++) tick(1, 1, 0);
        tick(1, 1, 1);
        checks++;
        if (rdy[1] !== 1'b1 || ful[1] !== 1'b0 || cnt1 !== 8'd0
            || dtaps(1) != 0) begin
            errors++;
            $display("FAIL clear_stall: rdy=%b full=%b cnt=%0d taps=%0h, want 1 0 0 0",
                     rdy[1], ful[1], cnt1, dtaps(1));
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 1);
        tick(1, 1, 0);
        tick(1, 1, 0);
        rst_n = 0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = mzero();
        checks++;
        if (dtaps(0) != 0 || ful[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: taps=%0h full=%b rdy=%b, want 0 0 1",
                     dtaps(0), ful[0], rdy[0]);
        end
        #2;
        rst_n = 1;
        for (int k = 0; k < 3; k++) tick(1, 1, 0);
        checks++;
        if (hit[0] !== 1'b0 || ful[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_refill3: hit=%b full=%b, want 0 0",
                     hit[0], ful[0]);
        end
        tick(1, 1, 0);
        checks++;
        if (hit[0] !== 1'b1 || cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL reset_refill4: hit=%b cnt=%0d, want 1 1",
                     hit[0], cnt0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 24) == 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dtaps(i) != m[i].taps || dcnt(i) != m[i].cnt
                    || hit[i] !== m[i].hit || rdy[i] !== !m[i].stall
                    || ful[i] !== (m[i].fill == 4)) begin
                    errors++;
                    $display("FAIL random u%0d cyc%0d: taps=%0h cnt=%0d hit=%b rdy=%b full=%b, want %0h %0d %b %b %b",
                             i, n, dtaps(i), dcnt(i), hit[i], rdy[i],
                             ful[i], m[i].taps, m[i].cnt, m[i].hit,
                             !m[i].stall, m[i].fill == 4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_pattern();
        test_overlap();
        test_stall();
        test_saturate();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/nand4_operand_shreg.md
Name: nand4_operand_shreg

Overview:
- Serial-in, parallel-out operand stage that sits directly upstream of the team's 4-input NAND gate models.
- Collects a serial bit stream under a valid/ready handshake into a 4-bit shift register.
- Presents the four taps as the NAND's a/b/c/d operands.
- Flags, registered and counted, every cycle where all four loaded taps are 1, i.e. the downstream NAND output goes low.

Parameters:
STALL_ON_HIT, 0, 1 = deassert o_ready for exactly one cycle after each detected hit; 0 = never stall
W_CNT, 8, width of the saturating hit counter (legal range 2..16)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  reset
i_valid  input  1  upstream has a bit on i_bit
i_bit  input  1  serial data bit
i_clear  input  1  synchronous flush of taps, fill state and hit counter
o_ready  output  1  stage can accept a bit this cycle
o_a  output  1  oldest tap, to NAND input a
o_b  output  1  tap 2, to NAND input b
o_c  output  1  tap 3, to NAND input c
o_d  output  1  newest tap, to NAND input d
o_full  output  1  four valid bits are loaded
o_hit  output  1  taps are full and equal 1111 this cycle
o_hit_cnt  output  W_CNT  saturating count of hits since reset/clear

Interface (decided): one clock, i_clk; reset i_rst_n is asynchronous and active-low.

Behaviour:
- Reset (i_rst_n=0, asynchronous)
  - Taps=0, fill=0, state=EMPTY, o_hit=0, o_hit_cnt=0, o_full=0.
  - o_ready=1 during and after reset.
- Accept
  - A bit is accepted at a rising edge iff i_valid & o_ready & ~i_clear.
  - On accept: {a,b,c,d} <= {b,c,d,i_bit}. Taps update at the accept edge (latency 1 edge).
  - With no accept, taps hold.
- Fill counter
  - 3-bit, 0..4, +1 per accept, saturates at 4. Never wraps.
- States (encoded 2-bit)
  - EMPTY: fill=0.
  - FILL: fill 1..3.
  - FULL: fill=4.
  - STALL: one-cycle hold after a hit.
- Transitions
  - EMPTY->FILL on accept.
  - FILL->FULL on the accept that makes fill=4.
  - FULL->STALL on a hit accept when STALL_ON_HIT=1; otherwise FULL stays FULL.
  - FILL->STALL when the 4th accept is a hit and STALL_ON_HIT=1.
  - STALL->FULL unconditionally after one cycle.
  - Any state->EMPTY on i_clear.
- o_ready = (state != STALL). It is a combinational decode of the state register only, with no dependence on i_valid.
- o_full = state in {FULL, STALL}.
- Hit detection
  - o_hit is registered: at an accept edge, o_hit <= (fill_next==4) & ({b,c,d,i_bit}==4'b1111).
  - At any non-accept edge, o_hit <= 0.
  - o_hit is therefore a one-cycle pulse coincident with taps showing 1111.
  - Overlapping hits count: a run of five 1s gives hits on bits 4 and 5.
- Hit counter
  - o_hit_cnt increments at the same edge o_hit is set.
  - Saturates at 2^W_CNT-1 and never wraps.
- Clear
  - i_clear has priority over accept. Any i_valid bit in that cycle is dropped, not accepted.
  - At the clear edge: taps=0, fill=0, o_hit=0, o_hit_cnt=0, state=EMPTY.
  - Clear in STALL exits STALL immediately.
- Stall
  - During STALL an i_valid bit is not accepted. Upstream holds it and it is accepted on the next cycle.
- Reset mid-fill discards partial taps. A full 4 new bits are required before o_full or o_hit.

Decomposition:
- Shared include/package holds:
  - State encodings: EMPTY=2'd0, FILL=2'd1, FULL=2'd2, STALL=2'd3.
  - FILL_MAX=3'd4.
  - The all-ones tap constant 4'b1111.
- One natural sub-module: sat_counter_v. Parameterised width, with inc, sync clear, and async active-low reset, all saturating. It implements o_hit_cnt.

Test Plan:
- Reset -> o_ready=1, o_a..o_d=0, o_full=0, o_hit=0, o_hit_cnt=0.
- Feed 1,0,1,1 with i_valid=1 -> after the 4th edge: a=1 b=0 c=1 d=1, o_full=1, o_hit=0, o_hit_cnt=0.
- STALL_ON_HIT=0, feed 1,1,1,1,1,0 back-to-back:
  - o_hit pulses after bits 4 and 5, giving o_hit_cnt=2.
  - After bit 6: taps 1110, o_hit=0.
- STALL_ON_HIT=1, feed 1,1,1,1 then hold i_valid=1, i_bit=1:
  - o_ready=0 for exactly the cycle after the hit.
  - The 5th bit is accepted one cycle late and hits again, giving o_hit_cnt=2.
- W_CNT=2, feed eight consecutive 1s (STALL_ON_HIT=0) -> five hits, o_hit_cnt saturates at 3.
- Clear and reset:
  - Assert i_clear with i_valid=1, i_bit=1 while FULL -> bit dropped, taps=0, state EMPTY, o_hit_cnt=0.
  - Separately, pulse i_rst_n low after 2 bits -> all outputs 0 at once, and 4 new 1s are needed before o_hit.
